// File: rtl/bit_stream_serializer_if.sv
// Word-in / bit-out bus of the bit stream serializer.
// master drives words and the shift enable; slave is the serializer itself.
interface bit_stream_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             enable;
  logic             serial_out;
  logic             serial_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output in_data, in_valid, enable,
    input  in_ready, serial_out, serial_valid, word_done, busy
  );

  modport slave (
    input  in_data, in_valid, enable,
    output in_ready, serial_out, serial_valid, word_done, busy
  );
endinterface

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial stage feeding a serial-pattern detector, one bit per enabled clock.
// Optional even-parity trailer bit: define SERIALIZER_PARITY_EN.
module bit_stream_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  bit_stream_serializer_if.slave  bus
);

`ifdef SERIALIZER_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int            CW   = $clog2(FL + 1);
  localparam logic [CW-1:0] LAST = CW'(FL - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
`ifdef SERIALIZER_PARITY_EN
  logic             r_parity;
`endif

  logic w_busy;
  logic w_last;
  logic w_ready;
  logic w_accept;
  logic w_head;
  logic w_bit;

  assign w_busy   = (r_state == S_SHIFT);
  // A stalled last bit is not "presented", so it neither completes the frame nor opens the port.
  assign w_last   = w_busy && bus.enable && (r_cnt == LAST);
  assign w_ready  = !w_busy || w_last;
  assign w_accept = bus.in_valid && w_ready;
  assign w_head   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

`ifdef SERIALIZER_PARITY_EN
  assign w_bit = (r_cnt == CW'(WIDTH)) ? r_parity : w_head;
`else
  assign w_bit = w_head;
`endif

  assign bus.in_ready     = w_ready;
  assign bus.busy         = w_busy;
  assign bus.word_done    = w_last;
  assign bus.serial_valid = w_busy && bus.enable;
  assign bus.serial_out   = (w_busy && bus.enable) ? w_bit : IDLE_BIT;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
  // reset is asynchronous, so it sits in the sensitivity list and wins over everything else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
`ifdef SERIALIZER_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state <= S_SHIFT;
      r_cnt   <= '0;
      r_shift <= bus.in_data;
`ifdef SERIALIZER_PARITY_EN
      r_parity <= ^bus.in_data;
`endif
    end else if (w_busy && bus.enable) begin
      if (w_last) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
        if (MSB_FIRST) r_shift <= {r_shift[WIDTH-2:0], 1'b0};
        else           r_shift <= {1'b0, r_shift[WIDTH-1:1]};
      end
    end
  end

endmodule
